// File: rtl/fpadd_arb_pkg.sv
// Shared types for the two-requester fpadd arbiter: FSM states, in-flight tag, data width.
package fpadd_arb_pkg;
   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      QUIESCED = 2'd2
   } state_t;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;
endpackage

// File: rtl/fpadd_arbiter_rr_arb2.sv
// Two-way round-robin grant; rr_last_reg remembers the most recent winner.
module fpadd_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] valid,
   output logic [1:0] grant
);
   logic rr_last_reg;

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (valid == 2'b11)
            grant = rr_last_reg ? 2'b01 : 2'b10;
         else
            grant = valid;
      end
   end

   // Reset to 1 so requester 0 wins the first contested cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_last_reg <= 1'b1;
      else if (grant != 2'b00)
         rr_last_reg <= grant[1];
   end
endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one pipelined fp adder between two requesters, routing results back by tag.
// Optional per-requester grant counters are built when FPADD_ARB_STATS_EN is defined.
module fpadd_arbiter
   import fpadd_arb_pkg::*;
#(
   parameter int ADD_LATENCY = 5,
   parameter int CNT_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [FP_W-1:0] req0_a,
   input  logic [FP_W-1:0] req0_b,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [FP_W-1:0] req1_a,
   input  logic [FP_W-1:0] req1_b,
   output logic            req1_ready,
   output logic [FP_W-1:0] fpa_a,
   output logic [FP_W-1:0] fpa_b,
   input  logic [FP_W-1:0] fpa_result,
   output logic            rsp0_valid,
   output logic [FP_W-1:0] rsp0_data,
   output logic            rsp1_valid,
   output logic [FP_W-1:0] rsp1_data,
   input  logic            quiesce_req,
   output logic            quiesce_ack,
   output logic            busy
`ifdef FPADD_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
`endif
);
   localparam int IF_W = $clog2(ADD_LATENCY + 3);

   state_t          state_reg, state_next;
   logic            grant_en;
   logic [1:0]      grant;
   logic            grant_any;
   logic [FP_W-1:0] fpa_a_reg, fpa_b_reg;
   tag_t            tag_reg [0:ADD_LATENCY];
   tag_t            tag_last;
   logic [IF_W-1:0] inflight_reg;
   logic            rsp_any;

   fpadd_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .enable (grant_en),
      .valid  ({req1_valid, req0_valid}),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign grant_any  = |grant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= RUN;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:      if (quiesce_req) state_next = DRAIN;
         DRAIN:    if (!quiesce_req) state_next = RUN;
                   else if (inflight_reg == '0) state_next = QUIESCED;
         QUIESCED: if (!quiesce_req) state_next = RUN;
         default:  state_next = RUN;
      endcase
   end

   // The quiesce request suppresses grants in the very cycle it is first seen.
   always_comb begin
      grant_en    = (state_reg == RUN) && !quiesce_req;
      quiesce_ack = (state_reg == QUIESCED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpa_a_reg <= '0;
         fpa_b_reg <= '0;
      end else if (grant_any) begin
         fpa_a_reg <= grant[1] ? req1_a : req0_a;
         fpa_b_reg <= grant[1] ? req1_b : req0_b;
      end
   end

   assign fpa_a = fpa_a_reg;
   assign fpa_b = fpa_b_reg;

   // Stage 0 lines up with fpa_a/fpa_b; the last stage lines up with fpa_result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= ADD_LATENCY; i++)
            tag_reg[i] <= '0;
      end else begin
         tag_reg[0] <= tag_t'{valid: grant_any, id: grant[1]};
         for (int i = 1; i <= ADD_LATENCY; i++)
            tag_reg[i] <= tag_reg[i-1];
      end
   end

   assign tag_last = tag_reg[ADD_LATENCY];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rsp
         logic            valid_reg;
         logic [FP_W-1:0] data_reg;
         logic            hit;

         assign hit = tag_last.valid && (tag_last.id == 1'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= hit;
               if (hit)
                  data_reg <= fpa_result;
            end
         end
      end
   endgenerate

   assign rsp0_valid = g_rsp[0].valid_reg;
   assign rsp0_data  = g_rsp[0].data_reg;
   assign rsp1_valid = g_rsp[1].valid_reg;
   assign rsp1_data  = g_rsp[1].data_reg;
   assign rsp_any    = rsp0_valid | rsp1_valid;

   // An operation stays counted through the cycle its response is visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         inflight_reg <= '0;
      else if (grant_any && !rsp_any)
         inflight_reg <= inflight_reg + IF_W'(1);
      else if (!grant_any && rsp_any)
         inflight_reg <= inflight_reg - IF_W'(1);
   end

   assign busy = (inflight_reg != '0);

`ifdef FPADD_ARB_STATS_EN
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stat
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               cnt_reg <= '0;
            else if (grant[gi] && (cnt_reg != '1))
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   endgenerate

   assign grant_cnt0 = g_stat[0].cnt_reg;
   assign grant_cnt1 = g_stat[1].cnt_reg;
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_fpadd_arbiter.sv
// Directed bench for fpadd_arbiter with a behavioural adder and a response scoreboard.
// Define FPADD_ARB_STATS_EN to also exercise the saturating grant counters.
module tb_fpadd_arbiter;
   localparam int L = 5;
`ifdef FPADD_ARB_STATS_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 16;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        req0_ready, req1_ready;
   logic [31:0] fpa_a, fpa_b, fpa_result;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_data, rsp1_data;
   logic        quiesce_req = 1'b0;
   logic        quiesce_ack, busy;
`ifdef FPADD_ARB_STATS_EN
   logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      int          due;
      logic [31:0] d;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   fpadd_arbiter #(.ADD_LATENCY(L), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .fpa_a       (fpa_a),
      .fpa_b       (fpa_b),
      .fpa_result  (fpa_result),
      .rsp0_valid  (rsp0_valid),
      .rsp0_data   (rsp0_data),
      .rsp1_valid  (rsp1_valid),
      .rsp1_data   (rsp1_data),
      .quiesce_req (quiesce_req),
      .quiesce_ack (quiesce_ack),
      .busy        (busy)
`ifdef FPADD_ARB_STATS_EN
      ,
      .grant_cnt0  (grant_cnt0),
      .grant_cnt1  (grant_cnt1)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Known single-precision sums; anything else maps through a fixed scramble.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3f800000, 32'h40000000}: return 32'h40400000;
         {32'h3f800000, 32'h3f800000}: return 32'h40000000;
         {32'h40000000, 32'h40000000}: return 32'h40800000;
         default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h5a5a0000;
      endcase
   endfunction

   logic [31:0] add_pipe [0:L-1];
   always @(posedge clk) begin
      add_pipe[0] <= fadd(fpa_a, fpa_b);
      for (int i = 1; i < L; i++) add_pipe[i] <= add_pipe[i-1];
   end
   assign fpa_result = add_pipe[L-1];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   // Scoreboard: every accepted op owes its owner one response L+2 cycles later.
   always @(negedge clk) begin
      if (!rst) begin
         q0.delete();
         q1.delete();
      end else begin
         chk("busy", 32'(busy), 32'((q0.size() + q1.size()) != 0));
         chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
         if (q0.size() > 0 && q0[0].due <= cyc) begin
            chk("rsp0_valid", 32'(rsp0_valid), 32'd1);
            chk("rsp0_data", rsp0_data, q0[0].d);
            $display("rsp0 @%0d data=%h", cyc, rsp0_data);
            void'(q0.pop_front());
         end else begin
            chk("rsp0_idle", 32'(rsp0_valid), 32'd0);
         end
         if (q1.size() > 0 && q1[0].due <= cyc) begin
            chk("rsp1_valid", 32'(rsp1_valid), 32'd1);
            chk("rsp1_data", rsp1_data, q1[0].d);
            $display("rsp1 @%0d data=%h", cyc, rsp1_data);
            void'(q1.pop_front());
         end else begin
            chk("rsp1_idle", 32'(rsp1_valid), 32'd0);
         end
         if (req0_valid && req0_ready) q0.push_back(exp_t'{cyc + L + 2, fadd(req0_a, req0_b)});
         if (req1_valid && req1_ready) q1.push_back(exp_t'{cyc + L + 2, fadd(req1_a, req1_b)});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_neg(input int target);
      forever begin
         @(negedge clk);
         if (cyc >= target) break;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      quiesce_req = 1'b0;
      step();
      step();
      chk("rst_fpa_a", fpa_a, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(quiesce_ack), 32'd0);
      chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      rst = 1'b1;
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, g, ack_cyc, d;

      // Single op from requester 0.
      do_reset();
      req0_valid = 1'b1; req0_a = 32'h3f800000; req0_b = 32'h40000000;
      @(negedge clk);
      c0 = cyc;
      chk("t1_ready0", 32'(req0_ready), 32'd1);
      chk("t1_ready1", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      wait_neg(c0 + L + 1);
      chk("t1_early", 32'(rsp0_valid), 32'd0);
      wait_neg(c0 + L + 2);
      chk("t1_valid", 32'(rsp0_valid), 32'd1);
      chk("t1_data", rsp0_data, 32'h40400000);
      chk("t1_rsp1", 32'(rsp1_valid), 32'd0);
      step();

      // Both requesters contend for four cycles: 0,1,0,1.
      do_reset();
      req0_valid = 1'b1; req0_a = 32'h3f800000; req0_b = 32'h3f800000;
      req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000;
      c0 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) c0 = cyc;
         chk("t2_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
         step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_neg(c0 + L + 2);
      chk("t2_r0_data", rsp0_data, 32'h40000000);
      wait_neg(c0 + L + 3);
      chk("t2_r1_valid", 32'(rsp1_valid), 32'd1);
      chk("t2_r1_data", rsp1_data, 32'h40800000);
      repeat (L + 4) step();

      // Ten back-to-back ops from requester 0.
      c0 = 0;
      for (int i = 0; i < 10; i++) begin
         req0_valid = 1'b1;
         req0_a = 32'h3f800000 + 32'(i);
         req0_b = 32'h40000000 + 32'(i << 4);
         @(negedge clk);
         c0 = cyc;
         chk("t3_ready", 32'(req0_ready), 32'd1);
         step();
      end
      req0_valid = 1'b0;
      wait_neg(c0 + L + 2);
      chk("t3_last_rsp", 32'(rsp0_valid), 32'd1);
      chk("t3_busy_hi", 32'(busy), 32'd1);
      wait_neg(c0 + L + 3);
      chk("t3_busy_lo", 32'(busy), 32'd0);
      step();

      // Quiesce with three ops in flight.
      g = 0;
      for (int i = 0; i < 3; i++) begin
         req0_valid = 1'b1;
         req0_a = 32'h41000000 + 32'(i);
         req0_b = 32'h41200000;
         @(negedge clk);
         g = cyc;
         chk("t4_issue", 32'(req0_ready), 32'd1);
         step();
      end
      quiesce_req = 1'b1;
      req0_a = 32'h42000000; req0_b = 32'h42100000;
      req1_valid = 1'b1; req1_a = 32'h43000000; req1_b = 32'h43100000;
      ack_cyc = -1;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         chk("t4_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         if (quiesce_ack) begin
            ack_cyc = cyc;
            break;
         end
      end
      chk("t4_ack_cycle", 32'(ack_cyc), 32'(g + L + 4));
      chk("t4_ack_idle", 32'(busy), 32'd0);
      step();
      quiesce_req = 1'b0;
      @(negedge clk);
      d = cyc;
      chk("t4_ack_hold", 32'(quiesce_ack), 32'd1);
      chk("t4_hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      wait_neg(d + 1);
      chk("t4_ack_drop", 32'(quiesce_ack), 32'd0);
      chk("t4_regrant", {30'd0, req1_ready, req0_ready}, 32'd2);
      step();
      req1_valid = 1'b0;
      @(negedge clk);
      chk("t4_req0_after", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      repeat (L + 4) step();

      // Asynchronous reset with four ops in flight.
      for (int i = 0; i < 4; i++) begin
         req1_valid = 1'b1;
         req1_a = 32'h44000000 + 32'(i);
         req1_b = 32'h44800000;
         @(negedge clk);
         chk("t5_issue", 32'(req1_ready), 32'd1);
         step();
      end
      req1_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_fpa_a", fpa_a, 32'd0);
      chk("t5_fpa_b", fpa_b, 32'd0);
      chk("t5_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("t5_ack", 32'(quiesce_ack), 32'd0);
      step();
      step();
      rst = 1'b1;
      repeat (15) step();
      chk("t5_after_busy", 32'(busy), 32'd0);

`ifdef FPADD_ARB_STATS_EN
      // Twenty grants saturate a 4-bit counter.
      do_reset();
      req1_valid = 1'b1; req1_a = 32'h45000000; req1_b = 32'h45100000;
      repeat (20) step();
      req1_valid = 1'b0;
      chk("t6_cnt1", 32'(grant_cnt1), 32'hF);
      chk("t6_cnt0", 32'(grant_cnt0), 32'h0);
      repeat (L + 4) step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one fpadd_pipelined instance between two requesters.
- Arbitrates with round-robin and drives registered operands into the adder.
- Tracks which requester owns each in-flight operation with a tag shift pipe, and routes each result back to its owner.
- Provides a quiesce handshake so the adder can be drained before the system reconfigures or observes it.

Parameters:
- ADD_LATENCY, 5, cycles from operands on fpa_a/fpa_b to the matching fpa_result. Must equal the adder's pipeline depth.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_a  in  32  requester 0 operand A (IEEE-754 single)
- req0_b  in  32  requester 0 operand B
- req0_ready  out  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready  same as above, for requester 1
- fpa_a  out  32  registered operand A to the adder
- fpa_b  out  32  registered operand B to the adder
- fpa_result  in  32  adder output
- rsp0_valid  out  1  one-cycle pulse: result for requester 0
- rsp0_data  out  32  result for requester 0
- rsp1_valid, rsp1_data  same as above, for requester 1
- quiesce_req  in  1  request to stop issuing and drain
- quiesce_ack  out  1  adder empty, no grants
- busy  out  1  one or more operations in flight
- grant_cnt0, grant_cnt1  out  CNT_W  present only with FPADD_ARB_STATS_EN

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - fpa_a/fpa_b = 0, rsp*_valid = 0, rsp*_data = 0
  - tag pipe all invalid
  - state = RUN, rr_last = 1 (so requester 0 wins first), in-flight count = 0
  - quiesce_ack = 0, busy = 0
- Reset mid-operation discards every in-flight operation. No response is ever produced for it.
- Handshake:
  - A transfer happens when reqN_valid=1 and reqN_ready=1 at a clock edge.
  - ready depends combinationally on both valids and on state. Requesters must not derive valid from ready.
  - A requester holds valid and operands stable until accepted.
- Arbitration (state RUN only):
  - If exactly one requester is valid, it is granted.
  - If both are valid, grant the requester other than rr_last.
  - rr_last updates only on a grant.
  - At most one ready is high per cycle. Sustained throughput is 1 operation/cycle.
- Issue: on a grant, fpa_a/fpa_b load the operands and tag pipe stage 0 loads {valid=1, id=N}. Otherwise fpa_a/fpa_b hold their value and stage 0 loads valid=0.
- Tag pipe:
  - ADD_LATENCY+1 stages.
  - The final stage aligns with fpa_result.
  - When the final stage is valid with id N, rspN_data <= fpa_result and rspN_valid <= 1 on the next edge. Otherwise both rsp valids are 0.
- Latency: handshake in cycle h means operands on fpa_a in h+1, fpa_result in h+1+ADD_LATENCY, and rspN_valid in h+2+ADD_LATENCY.
- Responses have no backpressure. Per requester, results return in issue order.
- In-flight counter:
  - Increments on a grant and decrements when rspN_valid asserts. Both in the same cycle leaves it unchanged.
  - Width is $clog2(ADD_LATENCY+3).
  - busy = (count != 0).
- FSM:
  - RUN: grants allowed. Goes to DRAIN when quiesce_req=1; no grant is issued in that cycle.
  - DRAIN: no grants. Goes to QUIESCED when count==0, or back to RUN when quiesce_req=0.
  - QUIESCED: quiesce_ack=1, no grants. Goes to RUN when quiesce_req=0, and quiesce_ack drops in the same edge.

Optional Feature:
- FPADD_ARB_STATS_EN defined:
  - grant_cnt0/grant_cnt1 count grants per requester, saturating at all-ones.
  - Reset to 0; never wrap.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package fpadd_arb_pkg holds:
  - state enum {RUN, DRAIN, QUIESCED}
  - tag struct {logic valid; logic id;}
  - constant FP_W=32
- One natural sub-module: fpadd_rr_arb2 (2-way round-robin grant with rr_last register).
- Tag pipe and FSM stay in the top module.

Test Plan:
- Reset then req0 alone with 3f800000+40000000: req0_ready=1 same cycle, and rsp0_valid pulses exactly ADD_LATENCY+2 cycles later with 40400000. rsp1_valid stays 0.
- Both valid for 4 consecutive cycles with req0 = 3f800000+3f800000 and req1 = 40000000+40000000: grants alternate 0,1,0,1. Responses are 40000000 and 40800000 respectively, back-to-back, each in order.
- Back-to-back req0 stream of 10 ops: one grant per cycle. busy stays 1 until the last response, then drops the cycle after.
- quiesce_req=1 with 3 ops in flight: no ready asserts, all 3 responses arrive, then quiesce_ack=1. After dropping quiesce_req, quiesce_ack=0 and a grant is possible in the next cycle.
- Assert rst=0 asynchronously with 4 ops in flight: outputs clear immediately, and no rsp*_valid follows after release.
- With FPADD_ARB_STATS_EN and CNT_W=4: 20 req1 grants leave grant_cnt1 = 0xF and grant_cnt0 = 0.
